// File: rtl/main_memory_burst.sv
// Main-memory burst model behind the L2: one line request, a fixed access latency,
// then BURST_LEN words, each marked by a toggle of stb.
module main_memory_burst #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = 8,
  parameter int DEPTH_WORDS = 1024,
  parameter int ACCESS_LAT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stb,
  output logic              busy,
  output logic              done
);

  localparam int K_W    = $clog2(BURST_LEN);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int LINE_W = IDX_W - K_W;
  localparam int LAT_W  = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LAT,
    XFER,
    HOLD,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                we_q, we_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                stb_q, stb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];
  logic [IDX_W-1:0]    mem_idx;
  logic                mem_wr;

  // Byte offset and line-offset bits, plus anything above the array size, never address the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_W-1:IDX_W+2], addr[K_W+1:0]};

  assign mem_idx = {line_q, k_q};

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    k_d     = k_q;
    we_d    = we_q;
    line_d  = line_q;
    stb_d   = stb_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mem_wr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = req;
        if (req) begin
          we_d    = we;
          line_d  = addr[IDX_W+1:K_W+2];
          lat_d   = '0;
          state_d = LAT;
        end
      end
      LAT: begin
        if (lat_q == LAT_W'(ACCESS_LAT - 1)) begin
          state_d = XFER;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      XFER: begin
        stb_d = ~stb_q;
        if (we_q) begin
          rdata_d = mem[mem_idx];
        end else begin
          mem_wr = 1'b1;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (k_q == K_W'(BURST_LEN - 1)) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = XFER;
        end
      end
      DONE: begin
        // done/busy are registered, so they trail the state by one cycle.
        done_d  = 1'b1;
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      k_q     <= '0;
      we_q    <= 1'b0;
      line_q  <= '0;
      stb_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      k_q     <= k_d;
      we_q    <= we_d;
      line_q  <= line_d;
      stb_q   <= stb_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Array contents survive reset; a burst cut short keeps the words it already wrote.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_idx] <= wdata;
    end
  end

  assign rdata = rdata_q;
  assign stb   = stb_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_main_memory_burst.sv
// Scoreboard bench for main_memory_burst: expected stb toggle times, read words and
// done pulses are queued at issue time and popped by an independent monitor.
module tb_main_memory_burst;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stb;
  logic        busy;
  logic        done;

  main_memory_burst dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .stb  (stb),
    .busy (busy),
    .done (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          rd;
    logic [31:0] data;
  } tog_t;

  tog_t        tog_q[$];
  int          done_q[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] wbuf [8];
  logic [31:0] last_rd;
  logic [31:0] lines[$];
  int          n_compared = 0;
  int          n_failed   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word index of word k of the line containing byte address a, wrapped to the array depth.
  function automatic int unsigned word_index(input logic [31:0] a, input int k);
    int unsigned w;
    w = a / 4;
    return ((w - (w % 8)) + k) % 1024;
  endfunction

  // Queue what a burst accepted at cycle t should produce and update the memory model.
  task automatic expect_burst(input logic rd, input logic [31:0] a, input int t, input int abort_n);
    tog_t e;
    for (int k = 0; k < 8; k++) begin
      e.at   = t + 5 + 2 * k;
      e.rd   = rd;
      e.data = ref_mem[word_index(a, k)];
      tog_q.push_back(e);
      if (!rd && (abort_n == 0 || k < abort_n)) ref_mem[word_index(a, k)] = wbuf[k];
    end
    if (abort_n == 0) begin
      done_q.push_back(t + 21);
      if (rd) last_rd = ref_mem[word_index(a, 7)];
    end
  endtask

  // Monitor: samples on the falling edge, pops one entry per stb edge and per done cycle.
  logic prev_stb = 1'b0;
  always @(negedge clk) begin
    tog_t t;
    int   d;
    if (!rst_n) begin
      prev_stb = stb;
    end else begin
      if (stb !== prev_stb) begin
        prev_stb = stb;
        if (tog_q.size() == 0) begin
          n_compared++;
          n_failed++;
          $display("[TB] FAIL stb_unexpected: toggle at cycle %0d, none expected", cyc);
        end else begin
          t = tog_q.pop_front();
          checkOutput("stb_cycle", cyc, t.at);
          if (t.rd) checkOutput("rdata", rdata, t.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_compared++;
          n_failed++;
          $display("[TB] FAIL done_unexpected: done at cycle %0d, none expected", cyc);
        end else begin
          d = done_q.pop_front();
          checkOutput("done_cycle", cyc, d);
        end
      end
    end
  end

  // One burst; abort_n > 0 drops rst_n between the abort_n-th toggle and the next word.
  task automatic applyStimulus(input logic rd, input logic [31:0] a, input int abort_n);
    int t0;
    @(negedge clk);
    req   = 1'b1;
    we    = rd;
    addr  = a;
    wdata = wbuf[0];
    @(negedge clk);
    t0   = cyc;
    req  = 1'b0;
    addr = $urandom;
    we   = 1'($urandom);
    checkOutput("busy_accept", busy, 1);
    expect_burst(rd, a, t0, abort_n);
    repeat (5) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      if (j < 7) wdata = wbuf[j+1];
      if (abort_n == j + 1) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_stb", stb, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rdata", rdata, 0);
        tog_q.delete();
        done_q.delete();
        last_rd = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_stb", stb, 0);
        return;
      end
      repeat (2) @(negedge clk);
    end
    checkOutput("busy_end", busy, 1);
    @(negedge clk);
    checkOutput("busy_fall", busy, 0);
    if (!rd) checkOutput("rdata_hold", rdata, last_rd);
  endtask

  task automatic fill_wbuf(input logic [31:0] base);
    for (int k = 0; k < 8; k++) wbuf[k] = base + 32'(k);
  endtask

  initial begin
    int t1, t2;
    logic [31:0] a;
    rst_n   = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    last_rd = '0;
    for (int i = 0; i < 8; i++) wbuf[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_stb", stb, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rdata", rdata, 0);
    rst_n = 1'b1;

    $display("[TB] write/read line 0x40");
    fill_wbuf(32'hA0);
    applyStimulus(1'b0, 32'h40, 0);
    applyStimulus(1'b1, 32'h40, 0);

    $display("[TB] reset during read burst");
    applyStimulus(1'b1, 32'h40, 3);

    $display("[TB] unaligned read and aliasing");
    applyStimulus(1'b1, 32'h5C, 0);
    applyStimulus(1'b1, 32'h1040, 0);
    fill_wbuf(32'hB0);
    applyStimulus(1'b0, 32'h1040, 0);
    applyStimulus(1'b1, 32'h40, 0);

    $display("[TB] write cut short by reset");
    fill_wbuf(32'hC0);
    applyStimulus(1'b0, 32'h80, 0);
    fill_wbuf(32'hD0);
    applyStimulus(1'b0, 32'h80, 3);
    applyStimulus(1'b1, 32'h80, 0);

    $display("[TB] back-to-back with held req");
    @(negedge clk);
    req  = 1'b1;
    we   = 1'b1;
    addr = 32'h40;
    @(negedge clk);
    t1 = cyc;
    expect_burst(1'b1, 32'h40, t1, 0);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i < 21) begin
        addr = $urandom;
        we   = 1'($urandom);
      end else begin
        addr = 32'h80;
        we   = 1'b1;
        checkOutput("b2b_busy_first", busy, 1);
      end
    end
    @(negedge clk);
    t2 = t1 + 22;
    checkOutput("b2b_busy_second", busy, 1);
    expect_burst(1'b1, 32'h80, t2, 0);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i < 21) begin
        req  = 1'($urandom);
        addr = $urandom;
        we   = 1'($urandom);
      end else begin
        req = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("b2b_busy_fall", busy, 0);
    repeat (30) @(negedge clk);
    checkOutput("b2b_idle", busy, 0);

    $display("[TB] randomized bursts");
    for (int n = 0; n < 12; n++) begin
      if (lines.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = $urandom & 32'h000F_FFE0;
        for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
        lines.push_back(a);
        applyStimulus(1'b0, a | 32'($urandom_range(0, 31)), 0);
      end else begin
        a = lines[$urandom_range(0, lines.size() - 1)];
        applyStimulus(1'b1, a + 32'($urandom_range(0, 31)), 0);
      end
    end

    repeat (10) @(negedge clk);
    checkOutput("tog_q_drained", tog_q.size(), 0);
    checkOutput("done_q_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
